// File: rtl/stream_fifo_prof_if.sv
// ---------------------------------------------------------------------------
// stream_fifo_prof_if
//   Handshake and profiling bundle for one stream_fifo_prof link.
//   slave  modport : the FIFO itself (consumes din/val_in/ready_downward and
//                    the profiling controls, drives everything else).
//   master modport : the environment around the FIFO (upstream producer,
//                    downstream consumer and profiling controller).
//   Signals:
//     din, val_in, ready_upward        upstream valid/ready side
//     dout, val_out, ready_downward    downstream valid/ready side
//     cnt_en, clr_cnt                  profiling enable / synchronous clear
//     occupancy, hwm, prog_full        fill level, high-water mark, threshold flag
//     full_cnt, empty_cnt, read_cnt    saturating profiling counters
// ---------------------------------------------------------------------------
interface stream_fifo_prof_if #(
    parameter int PAYLOAD_BITS = 128,
    parameter int ADDR_BITS    = 7,
    parameter int CNT_BITS     = 32
);
    logic [PAYLOAD_BITS-1:0] din;
    logic                    val_in;
    logic                    ready_upward;
    logic [PAYLOAD_BITS-1:0] dout;
    logic                    val_out;
    logic                    ready_downward;
    logic                    cnt_en;
    logic                    clr_cnt;
    logic [ADDR_BITS:0]      occupancy;
    logic [ADDR_BITS:0]      hwm;
    logic                    prog_full;
    logic [CNT_BITS-1:0]     full_cnt;
    logic [CNT_BITS-1:0]     empty_cnt;
    logic [CNT_BITS-1:0]     read_cnt;

    modport slave (
        input  din, val_in, ready_downward, cnt_en, clr_cnt,
        output ready_upward, dout, val_out,
        output occupancy, hwm, prog_full, full_cnt, empty_cnt, read_cnt
    );

    modport master (
        output din, val_in, ready_downward, cnt_en, clr_cnt,
        input  ready_upward, dout, val_out,
        input  occupancy, hwm, prog_full, full_cnt, empty_cnt, read_cnt
    );
endinterface

// File: rtl/stream_fifo_prof.sv
// ---------------------------------------------------------------------------
// stream_fifo_prof
//   Single-clock first-word-fall-through stream FIFO with link profiling.
//   Capacity is 2**ADDR_BITS words counting the word presented on dout.
//   Every output is a register; flags are computed from the next occupancy
//   so they are exact in the cycle the occupancy they describe is visible.
//   Ports:
//     clk      single clock
//     rst_n    synchronous active-low reset (discards all stored words)
//     bus      stream_fifo_prof_if.slave: handshake, head word, profiling
// ---------------------------------------------------------------------------
module stream_fifo_prof #(
    parameter int PAYLOAD_BITS     = 128,
    parameter int ADDR_BITS        = 7,
    parameter int PROG_FULL_THRESH = 10,
    parameter int CNT_BITS         = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    stream_fifo_prof_if.slave      bus
);

    localparam int                  DEPTH      = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS:0]  OCC_ZERO   = {(ADDR_BITS+1){1'b0}};
    localparam logic [ADDR_BITS:0]  OCC_TWO    = (ADDR_BITS+1)'(2);
    localparam logic [ADDR_BITS:0]  OCC_DEPTH  = (ADDR_BITS+1)'(DEPTH);
    localparam logic [ADDR_BITS:0]  OCC_THRESH = (ADDR_BITS+1)'(PROG_FULL_THRESH);
    localparam logic [CNT_BITS-1:0] CNT_ZERO   = {CNT_BITS{1'b0}};
    localparam logic [CNT_BITS-1:0] CNT_MAX    = {CNT_BITS{1'b1}};
    localparam logic [ADDR_BITS-1:0] PTR_ZERO  = {ADDR_BITS{1'b0}};
    localparam logic [ADDR_BITS-1:0] PTR_ONE   = (ADDR_BITS)'(1);
    localparam logic [PAYLOAD_BITS-1:0] DATA_ZERO = {PAYLOAD_BITS{1'b0}};

    // Saturating increment: a counter parks at all-ones instead of wrapping.
    function automatic logic [CNT_BITS-1:0] sat_inc(
        input logic [CNT_BITS-1:0] value,
        input logic                inc
    );
        if (inc && (value != CNT_MAX)) begin
            return value + CNT_BITS'(1);
        end else begin
            return value;
        end
    endfunction

    // Running maximum used for the high-water mark.
    function automatic logic [ADDR_BITS:0] occ_max(
        input logic [ADDR_BITS:0] a,
        input logic [ADDR_BITS:0] b
    );
        if (a > b) begin
            return a;
        end else begin
            return b;
        end
    endfunction

    // Storage. The head word is also copied into dout_r; the memory entry at
    // rd_ptr_r always mirrors it, so the word behind the head is at rd_ptr_r+1.
    logic [PAYLOAD_BITS-1:0] mem_r [DEPTH];

    logic [ADDR_BITS-1:0]    wr_ptr_r;
    logic [ADDR_BITS-1:0]    rd_ptr_r;
    logic [ADDR_BITS:0]      occ_r;
    logic                    rdy_up_r;
    logic                    val_out_r;
    logic                    prog_full_r;
    logic [PAYLOAD_BITS-1:0] dout_r;
    logic [ADDR_BITS:0]      hwm_r;
    logic [CNT_BITS-1:0]     full_cnt_r;
    logic [CNT_BITS-1:0]     empty_cnt_r;
    logic [CNT_BITS-1:0]     read_cnt_r;

    logic                    wr_s;
    logic                    rd_s;
    logic [ADDR_BITS:0]      occ_nxt_s;
    logic [ADDR_BITS-1:0]    rd_ptr_inc_s;
    logic                    load_s;
    logic [PAYLOAD_BITS-1:0] head_nxt_s;

    // Handshake qualification and next occupancy.
    always_comb begin
        wr_s         = bus.val_in & rdy_up_r;
        rd_s         = val_out_r & bus.ready_downward;
        occ_nxt_s    = occ_r + (ADDR_BITS+1)'(wr_s) - (ADDR_BITS+1)'(rd_s);
        rd_ptr_inc_s = rd_ptr_r + PTR_ONE;
    end

    // Next head word. From empty a write falls straight through; on a read the
    // following stored word loads, or the incoming word when it is the only
    // one left (bypass, because the memory write lands on the same edge).
    always_comb begin
        load_s     = 1'b0;
        head_nxt_s = dout_r;
        if (occ_r == OCC_ZERO) begin
            if (wr_s) begin
                load_s     = 1'b1;
                head_nxt_s = bus.din;
            end else begin
                load_s     = 1'b0;
            end
        end else if (rd_s) begin
            if (occ_r >= OCC_TWO) begin
                load_s     = 1'b1;
                head_nxt_s = mem_r[rd_ptr_inc_s];
            end else if (wr_s) begin
                load_s     = 1'b1;
                head_nxt_s = bus.din;
            end else begin
                load_s     = 1'b0;
            end
        end else begin
            load_s = 1'b0;
        end
    end

    // Memory write port; stale entries after reset are unreachable via pointers.
    always_ff @(posedge clk) begin
        if (wr_s) begin
            mem_r[wr_ptr_r] <= bus.din;
        end
    end

    // Pointers, occupancy, head register and handshake flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r    <= PTR_ZERO;
            rd_ptr_r    <= PTR_ZERO;
            occ_r       <= OCC_ZERO;
            rdy_up_r    <= 1'b0;
            val_out_r   <= 1'b0;
            prog_full_r <= 1'b0;
            dout_r      <= DATA_ZERO;
        end else begin
            if (wr_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (rd_s) begin
                rd_ptr_r <= rd_ptr_inc_s;
            end
            if (load_s) begin
                dout_r <= head_nxt_s;
            end
            occ_r       <= occ_nxt_s;
            rdy_up_r    <= (occ_nxt_s < OCC_DEPTH);
            val_out_r   <= (occ_nxt_s != OCC_ZERO);
            prog_full_r <= (occ_nxt_s >= OCC_THRESH);
        end
    end

    // Profiling counters and high-water mark; clear wins over counting.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hwm_r       <= OCC_ZERO;
            full_cnt_r  <= CNT_ZERO;
            empty_cnt_r <= CNT_ZERO;
            read_cnt_r  <= CNT_ZERO;
        end else if (bus.clr_cnt) begin
            hwm_r       <= OCC_ZERO;
            full_cnt_r  <= CNT_ZERO;
            empty_cnt_r <= CNT_ZERO;
            read_cnt_r  <= CNT_ZERO;
        end else if (bus.cnt_en) begin
            hwm_r       <= occ_max(hwm_r, occ_nxt_s);
            full_cnt_r  <= sat_inc(full_cnt_r, ~rdy_up_r);
            empty_cnt_r <= sat_inc(empty_cnt_r, ~val_out_r);
            read_cnt_r  <= sat_inc(read_cnt_r, rd_s);
        end else begin
            hwm_r       <= hwm_r;
            full_cnt_r  <= full_cnt_r;
            empty_cnt_r <= empty_cnt_r;
            read_cnt_r  <= read_cnt_r;
        end
    end

    assign bus.ready_upward = rdy_up_r;
    assign bus.val_out      = val_out_r;
    assign bus.dout         = dout_r;
    assign bus.occupancy    = occ_r;
    assign bus.prog_full    = prog_full_r;
    assign bus.hwm          = hwm_r;
    assign bus.full_cnt     = full_cnt_r;
    assign bus.empty_cnt    = empty_cnt_r;
    assign bus.read_cnt     = read_cnt_r;

endmodule

// File: tb/tb_stream_fifo_prof.sv
// Testbench for stream_fifo_prof: small configuration (8 words, prog_full at 6,
// 8-bit counters so saturation is reachable). A behavioural model with a data
// queue tracks expected state; a short table covers reset and first-word
// latency, hand sequences cover the multi-cycle corner cases, then random
// traffic.
module tb_stream_fifo_prof;

    localparam int PB     = 32;
    localparam int AB     = 3;
    localparam int CB     = 8;
    localparam int DEPTH  = 8;
    localparam int THRESH = 6;
    localparam int CMAX   = 255;

    logic clk;
    logic rst_n;

    stream_fifo_prof_if #(.PAYLOAD_BITS(PB), .ADDR_BITS(AB), .CNT_BITS(CB)) bus ();

    stream_fifo_prof #(
        .PAYLOAD_BITS(PB), .ADDR_BITS(AB), .PROG_FULL_THRESH(THRESH), .CNT_BITS(CB)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // behavioural model state
    logic [PB-1:0] sb[$];
    int            m_occ, m_hwm, m_full, m_empty, m_read;
    logic          m_rdy, m_vout, m_pf;
    logic [PB-1:0] m_dout;

    typedef struct {
        logic          rst_n;
        logic          val_in;
        logic [PB-1:0] din;
        logic          rdy_dn;
        int            e_occ;
        logic          e_vout;
        logic          e_rdy;
        logic [PB-1:0] e_dout;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive at negedge, advance the model, check after the edge.
    task automatic cycle(input logic rst, input logic vin, input logic [PB-1:0] d,
                         input logic rdn, input logic cen, input logic clr);
        logic wr, rd;
        int   nxt;
        @(negedge clk);
        rst_n              = rst;
        bus.val_in         = vin;
        bus.din            = d;
        bus.ready_downward = rdn;
        bus.cnt_en         = cen;
        bus.clr_cnt        = clr;
        if (!rst) begin
            sb.delete();
            m_occ = 0; m_hwm = 0; m_full = 0; m_empty = 0; m_read = 0;
            m_rdy = 1'b0; m_vout = 1'b0; m_pf = 1'b0; m_dout = '0;
        end else begin
            wr = vin && m_rdy;
            rd = m_vout && rdn;
            if (rd) chk("dout_order", 64'(bus.dout), 64'(sb.pop_front()));
            if (wr) sb.push_back(d);
            nxt = m_occ + int'(wr) - int'(rd);
            if (clr) begin
                m_full = 0; m_empty = 0; m_read = 0; m_hwm = 0;
            end else if (cen) begin
                if (!m_rdy && m_full < CMAX) m_full++;
                if (!m_vout && m_empty < CMAX) m_empty++;
                if (rd && m_read < CMAX) m_read++;
                if (nxt > m_hwm) m_hwm = nxt;
            end
            m_occ  = nxt;
            m_rdy  = (nxt < DEPTH);
            m_pf   = (nxt >= THRESH);
            m_vout = (nxt != 0);
            if (sb.size() > 0) m_dout = sb[0];
        end
        @(posedge clk);
        #1;
        chk("occupancy", 64'(bus.occupancy), 64'(m_occ));
        chk("ready_upward", 64'(bus.ready_upward), 64'(m_rdy));
        chk("val_out", 64'(bus.val_out), 64'(m_vout));
        chk("prog_full", 64'(bus.prog_full), 64'(m_pf));
        chk("dout", 64'(bus.dout), 64'(m_dout));
        chk("hwm", 64'(bus.hwm), 64'(m_hwm));
        chk("full_cnt", 64'(bus.full_cnt), 64'(m_full));
        chk("empty_cnt", 64'(bus.empty_cnt), 64'(m_empty));
        chk("read_cnt", 64'(bus.read_cnt), 64'(m_read));
    endtask

    initial begin
        rst_n = 1'b0;
        bus.val_in = 1'b0; bus.din = '0; bus.ready_downward = 1'b0;
        bus.cnt_en = 1'b1; bus.clr_cnt = 1'b0;
        sb.delete();
        m_occ = 0; m_hwm = 0; m_full = 0; m_empty = 0; m_read = 0;
        m_rdy = 1'b0; m_vout = 1'b0; m_pf = 1'b0; m_dout = '0;

        // rst, vin, din, rdy_dn, occ, vout, rdy, dout (after the edge)
        tbl[0] = '{1'b0, 1'b0, 32'h0,  1'b0, 0, 1'b0, 1'b0, 32'h0};
        tbl[1] = '{1'b0, 1'b0, 32'h0,  1'b0, 0, 1'b0, 1'b0, 32'h0};
        tbl[2] = '{1'b1, 1'b0, 32'h0,  1'b0, 0, 1'b0, 1'b1, 32'h0};
        tbl[3] = '{1'b1, 1'b1, 32'hA5, 1'b0, 1, 1'b1, 1'b1, 32'hA5};
        tbl[4] = '{1'b1, 1'b0, 32'h0,  1'b1, 0, 1'b0, 1'b1, 32'hA5};
        tbl[5] = '{1'b1, 1'b1, 32'h3C, 1'b1, 1, 1'b1, 1'b1, 32'h3C};
        tbl[6] = '{1'b1, 1'b1, 32'h5A, 1'b1, 1, 1'b1, 1'b1, 32'h5A};
        tbl[7] = '{1'b1, 1'b0, 32'h0,  1'b0, 1, 1'b1, 1'b1, 32'h5A};

        for (int i = 0; i < 8; i++) begin
            cycle(tbl[i].rst_n, tbl[i].val_in, tbl[i].din, tbl[i].rdy_dn, 1'b1, 1'b0);
            chk("tbl_occ", 64'(bus.occupancy), 64'(tbl[i].e_occ));
            chk("tbl_vout", 64'(bus.val_out), 64'(tbl[i].e_vout));
            chk("tbl_rdy", 64'(bus.ready_upward), 64'(tbl[i].e_rdy));
            chk("tbl_dout", 64'(bus.dout), 64'(tbl[i].e_dout));
        end
        chk("tbl_read_cnt", 64'(bus.read_cnt), 64'd2);

        // Fill to full, push against full, then drain in order.
        cycle(1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b1);
        for (int i = 1; i <= 8; i++) cycle(1'b1, 1'b1, PB'(i), 1'b0, 1'b1, 1'b0);
        chk("full_rdy", 64'(bus.ready_upward), 64'd0);
        chk("full_occ", 64'(bus.occupancy), 64'd8);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 32'h99, 1'b0, 1'b1, 1'b0);
        chk("full_cnt3", 64'(bus.full_cnt), 64'd3);
        chk("full_occ_hold", 64'(bus.occupancy), 64'd8);
        chk("full_head", 64'(bus.dout), 64'd1);
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b0);
        chk("drain_empty", 64'(bus.val_out), 64'd0);
        chk("drain_last", 64'(bus.dout), 64'd8);
        chk("drain_hwm", 64'(bus.hwm), 64'd8);

        // Occupancy 4 with continuous streaming.
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, PB'(32'h100 + i), 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 100; i++) cycle(1'b1, 1'b1, PB'(32'h200 + i), 1'b1, 1'b1, 1'b0);
        chk("stream_occ", 64'(bus.occupancy), 64'd4);
        chk("stream_reads", 64'(bus.read_cnt), 64'd100);
        chk("stream_hwm", 64'(bus.hwm), 64'd4);

        // prog_full threshold crossing.
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, PB'(32'h300 + i), 1'b0, 1'b1, 1'b0);
        chk("pf_at5", 64'(bus.prog_full), 64'd0);
        cycle(1'b1, 1'b1, 32'h305, 1'b0, 1'b1, 1'b0);
        chk("pf_occ6", 64'(bus.occupancy), 64'd6);
        chk("pf_at6", 64'(bus.prog_full), 64'd1);
        cycle(1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b0);
        chk("pf_after_read", 64'(bus.prog_full), 64'd0);

        // Idle saturation of empty_cnt, then clear.
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 300; i++) cycle(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        chk("empty_sat", 64'(bus.empty_cnt), 64'd255);
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b1);
        chk("empty_clr", 64'(bus.empty_cnt), 64'd0);

        // Reset with 5 words stored.
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, PB'(32'h400 + i), 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        chk("rst_occ", 64'(bus.occupancy), 64'd0);
        chk("rst_vout", 64'(bus.val_out), 64'd0);
        chk("rst_rdy", 64'(bus.ready_upward), 64'd0);
        chk("rst_empty_cnt", 64'(bus.empty_cnt), 64'd0);
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        chk("rst_release_rdy", 64'(bus.ready_upward), 64'd1);

        // Random traffic with counters occasionally paused.
        for (int i = 0; i < 400; i++)
            cycle(1'b1, 1'($urandom_range(0, 1)), PB'($urandom), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 7) != 0), 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b0);
        chk("final_empty", 64'(bus.occupancy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
